// File: rtl/alu_shift_pkg.sv
// Shared types for the multi-cycle ALU shifter: operation encoding and FSM states.
package alu_shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bus of the shifter: valid/ready on both sides plus busy status.
interface shift_unit_if
   import alu_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   shift_op_e          in_op;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               busy;

   modport master (
      output in_valid, in_data, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/shift_stage.sv
// One shifter stage: optionally shifts/rotates the operand by 2^k according to op.
module shift_stage
   import alu_shift_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned K_W   = $clog2($clog2(WIDTH))
) (
   input  logic [WIDTH-1:0] data,
   input  shift_op_e        op,
   input  logic             fill,
   input  logic [K_W-1:0]   k,
   input  logic             en,
   output logic [WIDTH-1:0] shifted
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   logic [SHAMT_W-1:0] amt;
   logic [SHAMT_W:0]   ramt;
   logic [WIDTH-1:0]   ones;
   logic [WIDTH-1:0]   fill_mask;

   // amt never exceeds WIDTH/2, so the rotate complement stays in range
   always_comb begin
      amt       = SHAMT_W'(1) << k;
      ramt      = (SHAMT_W+1)'(WIDTH) - {1'b0, amt};
      ones      = '1;
      fill_mask = fill ? ~(ones >> amt) : '0;
      shifted   = data;
      if (en) begin
         unique case (op)
            SHIFT_SLL: shifted = data << amt;
            SHIFT_SRL: shifted = data >> amt;
            SHIFT_SRA: shifted = (data >> amt) | fill_mask;
            SHIFT_ROR: shifted = (data >> amt) | (data << ramt);
            default:   shifted = data;
         endcase
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter resolving one shift-amount bit per clock behind valid/ready handshakes.
module shift_unit
   import alu_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   shift_unit_if.slave bus
);
   localparam int unsigned    SHAMT_W = $clog2(WIDTH);
   localparam int unsigned    K_W     = $clog2(SHAMT_W);
   localparam logic [K_W-1:0] K_LAST  = K_W'(SHAMT_W - 1);

   state_e             state;
   state_e             state_next;
   logic [K_W-1:0]     k;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   stage_out;
   logic [SHAMT_W-1:0] sh;
   shift_op_e          op_r;
   logic               fill;
   logic               in_ready_c;
   logic               accept;
   logic               out_hs;
   logic               out_valid_q;
   logic               busy_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // DONE with a same-cycle accept skips IDLE to keep one result per SHAMT_W+1 cycles
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (k == K_LAST) state_next = DONE;
         DONE: begin
            if (accept)      state_next = BUSY;
            else if (out_hs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
      accept     = bus.in_valid && in_ready_c;
      out_hs     = out_valid_q && bus.out_ready;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc         <= '0;
         sh          <= '0;
         op_r        <= SHIFT_SLL;
         fill        <= 1'b0;
         k           <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= (state_next == DONE);
         busy_q      <= (state_next != IDLE);
         if (accept) begin
            acc  <= bus.in_data;
            sh   <= bus.in_shamt;
            op_r <= bus.in_op;
            fill <= (bus.in_op == SHIFT_SRA) && bus.in_data[WIDTH-1];
            k    <= '0;
         end else if (state == BUSY) begin
            acc <= stage_out;
            k   <= (k == K_LAST) ? '0 : k + K_W'(1);
         end
      end
   end

   shift_stage #(.WIDTH(WIDTH)) u_stage (
      .data    (acc),
      .op      (op_r),
      .fill    (fill),
      .k       (k),
      .en      (sh[k]),
      .shifted (stage_out)
   );

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = acc;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit at WIDTH=32 and WIDTH=8 against a bitwise reference model.
module tb_shift_unit;
   import alu_shift_pkg::*;

   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   shift_unit_if #(.WIDTH(32)) bus32 ();
   shift_unit_if #(.WIDTH(8))  bus8 ();

   shift_unit #(.WIDTH(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32.slave));
   shift_unit #(.WIDTH(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(bus8.slave));

   always #5 clock = ~clock;

   // Reference: each result bit picked directly from the operand by the op's rule
   function automatic logic [31:0] model(input int op, input logic [31:0] d, input int s, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (op)
            0:       r[i] = (i >= s)    ? d[i-s] : 1'b0;
            1:       r[i] = (i + s < w) ? d[i+s] : 1'b0;
            2:       r[i] = (i + s < w) ? d[i+s] : d[w-1];
            default: r[i] = d[(i+s)%w];
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run32(input int op, input logic [31:0] d, input int s,
                        output logic [31:0] res, output int lat);
      bus32.in_valid = 1'b1;
      bus32.in_data  = d;
      bus32.in_shamt = 5'(s);
      bus32.in_op    = shift_op_e'(op);
      tick();
      bus32.in_valid = 1'b0;
      lat = 0;
      while (!bus32.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = bus32.out_data;
      bus32.out_ready = 1'b1;
      tick();
      bus32.out_ready = 1'b0;
   endtask

   task automatic run8(input int op, input logic [7:0] d, input int s,
                       output logic [7:0] res, output int lat);
      bus8.in_valid = 1'b1;
      bus8.in_data  = d;
      bus8.in_shamt = 3'(s);
      bus8.in_op    = shift_op_e'(op);
      tick();
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = bus8.out_data;
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks += 8;
      if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL reset32_in_ready: got %b expected 1", bus32.in_ready); end
      if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset32_out_valid: got %b expected 0", bus32.out_valid); end
      if (bus32.busy !== 1'b0) begin errors++; $display("FAIL reset32_busy: got %b expected 0", bus32.busy); end
      if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL reset32_out_data: got %h expected 0", bus32.out_data); end
      if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset8_in_ready: got %b expected 1", bus8.in_ready); end
      if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset8_out_valid: got %b expected 0", bus8.out_valid); end
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset8_busy: got %b expected 0", bus8.busy); end
      if (bus8.out_data !== 8'h0) begin errors++; $display("FAIL reset8_out_data: got %h expected 0", bus8.out_data); end
   endtask

   task automatic test_directed();
      int          ops [8]  = '{2, 1, 0, 3, 0, 1, 2, 3};
      logic [31:0] din [8]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_00F1,
                                32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      int          sa  [8]  = '{4, 4, 31, 4, 0, 0, 0, 0};
      logic [31:0] exp [8]  = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1000_000F,
                                32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         run32(ops[i], din[i], sa[i], res, lat);
         checks += 2;
         if (res !== exp[i]) begin
            errors++;
            $display("FAIL directed_%0d_data: op %0d shamt %0d got %h expected %h", i, ops[i], sa[i], res, exp[i]);
         end
         if (lat != 5) begin
            errors++;
            $display("FAIL directed_%0d_latency: got %0d expected 5", i, lat);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus32.in_valid = 1'b1;
      bus32.in_data  = 32'h8000_0000;
      bus32.in_shamt = 5'd4;
      bus32.in_op    = SHIFT_SRA;
      tick();
      bus32.in_data  = 32'hDEAD_BEEF;
      bus32.in_shamt = 5'd1;
      bus32.in_op    = SHIFT_SLL;
      lat = 0;
      while (!bus32.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL bp_latency: got %0d expected 5", lat); end
      for (int c = 0; c < 4; c++) begin
         checks += 3;
         if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_%0d: got %b expected 1", c, bus32.out_valid); end
         if (bus32.out_data !== 32'hF800_0000) begin errors++; $display("FAIL bp_hold_data_%0d: got %h expected f8000000", c, bus32.out_data); end
         if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b expected 0", c, bus32.in_ready); end
         if (c < 3) tick();
      end
      bus32.in_valid  = 1'b0;
      bus32.out_ready = 1'b1;
      tick();
      bus32.out_ready = 1'b0;
      checks += 2;
      if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", bus32.out_valid); end
      if (bus32.busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", bus32.busy); end
   endtask

   task automatic test_back_to_back();
      int          cyc = 0;
      int          first = -1;
      int          second = -1;
      logic [31:0] r1 = '0;
      logic [31:0] r2 = '0;
      bus32.out_ready = 1'b1;
      bus32.in_valid  = 1'b1;
      bus32.in_data   = 32'hFFFF_FF00;
      bus32.in_shamt  = 5'd8;
      bus32.in_op     = SHIFT_SRA;
      tick();
      bus32.in_data   = 32'h0000_0001;
      bus32.in_shamt  = 5'd3;
      bus32.in_op     = SHIFT_SLL;
      while (cyc < 40 && second < 0) begin
         if (bus32.out_valid) begin
            if (first < 0) begin
               first = cyc;
               r1 = bus32.out_data;
               checks++;
               if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", bus32.in_ready); end
            end else begin
               second = cyc;
               r2 = bus32.out_data;
            end
         end
         tick();
         cyc++;
         if (first >= 0 && second < 0 && bus32.in_valid) begin
            bus32.in_valid = 1'b0;
            checks += 2;
            if (bus32.busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept_busy: got %b expected 1", bus32.busy); end
            if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_reaccept_valid: got %b expected 0", bus32.out_valid); end
         end
      end
      bus32.out_ready = 1'b0;
      checks += 5;
      if (r1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_first_data: got %h expected ffffffff", r1); end
      if (r2 !== 32'h0000_0008) begin errors++; $display("FAIL b2b_second_data: got %h expected 00000008", r2); end
      if (first != 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", first); end
      if (second - first != 6) begin errors++; $display("FAIL b2b_spacing: got %0d expected 6", second - first); end
      if (bus32.busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy: got %b expected 0", bus32.busy); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      logic [31:0] exp;
      int          lat;
      bit          leaked = 1'b0;
      bus32.in_valid = 1'b1;
      bus32.in_data  = 32'hDEAD_BEEF;
      bus32.in_shamt = 5'd4;
      bus32.in_op    = SHIFT_SRL;
      tick();
      bus32.in_valid = 1'b0;
      tick();
      checks++;
      if (bus32.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", bus32.busy); end
      #3;
      reset_n = 1'b0;
      #1;
      checks += 3;
      if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus32.out_valid); end
      if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus32.in_ready); end
      if (bus32.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus32.busy); end
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus32.out_valid !== 1'b0) leaked = 1'b1;
      end
      checks++;
      if (leaked) begin errors++; $display("FAIL rst_mid_no_output: got 1 expected 0"); end
      exp = model(3, 32'h1234_5678, 8, 32);
      run32(3, 32'h1234_5678, 8, res, lat);
      checks += 2;
      if (res !== exp) begin errors++; $display("FAIL rst_mid_fresh_data: got %h expected %h", res, exp); end
      if (lat != 5) begin errors++; $display("FAIL rst_mid_fresh_latency: got %0d expected 5", lat); end
   endtask

   task automatic test_sweep32();
      logic [31:0] d;
      logic [31:0] res;
      logic [31:0] exp;
      int          lat;
      for (int op = 0; op < 4; op++) begin
         for (int s = 0; s < 32; s++) begin
            d   = $urandom;
            exp = model(op, d, s, 32);
            run32(op, d, s, res, lat);
            checks += 2;
            if (res !== exp) begin errors++; $display("FAIL sweep32_data: op %0d shamt %0d in %h got %h expected %h", op, s, d, res, exp); end
            if (lat != 5) begin errors++; $display("FAIL sweep32_latency: op %0d shamt %0d got %0d expected 5", op, s, lat); end
         end
      end
   endtask

   task automatic test_sweep8();
      logic [31:0] d;
      logic [7:0]  res;
      logic [31:0] exp;
      int          lat;
      for (int op = 0; op < 4; op++) begin
         for (int s = 0; s < 8; s++) begin
            d   = {24'h0, 8'($urandom)};
            exp = model(op, d, s, 8);
            run8(op, d[7:0], s, res, lat);
            checks += 2;
            if (res !== exp[7:0]) begin errors++; $display("FAIL sweep8_data: op %0d shamt %0d in %h got %h expected %h", op, s, d[7:0], res, exp[7:0]); end
            if (lat != 3) begin errors++; $display("FAIL sweep8_latency: op %0d shamt %0d got %0d expected 3", op, s, lat); end
         end
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      bus32.in_valid  = 1'b0;
      bus32.in_data   = '0;
      bus32.in_shamt  = '0;
      bus32.in_op     = SHIFT_SLL;
      bus32.out_ready = 1'b0;
      bus8.in_valid   = 1'b0;
      bus8.in_data    = '0;
      bus8.in_shamt   = '0;
      bus8.in_op      = SHIFT_SLL;
      bus8.out_ready  = 1'b0;
      repeat (3) tick();
      test_reset();
      reset_n = 1'b1;
      tick();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_sweep32();
      test_sweep8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
